genetic_eval_ctrl: RTL
======================

Name: genetic_eval_ctrl

Overview:
Sequencer for the evolvable logic-element grid. It receives a candidate chromosome serially, one bit per cycle, and holds it in a register. That register drives the grid's truth tables (saidas_LE) and output-mux selects (out_chrom). The block then sweeps every input vector through the combinational grid, compares the grid outputs against a target truth-table memory, and reports a fitness count. It sits between the serial chromosome source (GA engine / host link) and the grid instance.

Parameters:
ROW, 2, grid rows
COL, 2, grid columns
IN, 2, grid primary inputs; 2^IN vectors are evaluated
OUT, 1, grid outputs
SETTLE, 2, cycles each vector is held before sampling; must be >=1
SELW, $clog2(ROW*COL), width of one out_chrom select (derived)
CHROM_BITS, ROW*COL*16+OUT*SELW, chromosome length (derived)
FITW, IN+$clog2(OUT+1), fitness width (derived)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  serial chromosome bit strobe
cfg_bit  in  1  serial chromosome data
cfg_ready  out  1  high when state is IDLE (bits are accepted)
start  in  1  request evaluation
busy  out  1  high in APPLY/SAMPLE
saidas_LE  out  ROW*COL*16  packed [ROW][COL][16] truth tables to grid
out_chrom  out  OUT*SELW  packed [OUT][SELW] output selects to grid
inp  out  IN  current input vector to grid
out  in  OUT  grid outputs
tgt_addr  out  IN  target memory address (equals current vector)
tgt_data  in  OUT  target outputs, synchronous read, 1-cycle latency
fitness  out  FITW  count of matching output bits
done  out  1  one-cycle pulse at end of evaluation
perfect  out  1  fitness == 2^IN*OUT, valid from done until next start

Behaviour:
- Reset (rst=1 at an edge): state IDLE; chromosome register, bit counter, vector counter, settle counter, fitness, done, perfect, inp, and tgt_addr all 0. Reset mid-operation aborts with no done pulse. The chromosome must then be reloaded.
- Chromosome register C = {saidas_LE, out_chrom}, CHROM_BITS wide, bits shifted in MSB-first. In IDLE, on cfg_valid: C <= {C[CHROM_BITS-2:0], cfg_bit}, and bitcnt increments, saturating at CHROM_BITS. After exactly CHROM_BITS bits, the first bit received is C[CHROM_BITS-1]. Extra bits keep shifting; bitcnt stays saturated.
- loaded = (registered bitcnt == CHROM_BITS). In IDLE, start is accepted only when loaded=1; otherwise it is ignored. If start and the final cfg bit arrive in the same cycle, start is ignored.
- States:
  - IDLE: waits for start. On accept: fitness<=0, perfect<=0, vec<=0, scnt<=0, then go to APPLY.
  - APPLY: inp=vec, tgt_addr=vec; scnt counts 0..SETTLE-1, then go to SAMPLE.
  - SAMPLE: fitness += popcount(~(out ^ tgt_data)). If vec==2^IN-1, go to DONE; else vec++, scnt<=0, go to APPLY. inp/tgt_addr stay at vec during SAMPLE.
  - DONE: done=1 for this cycle; perfect <= (final fitness == 2^IN*OUT); bitcnt<=0; go to IDLE.
- Timing: if start is accepted at cycle 0, done is high at cycle 2^IN*(SETTLE+1)+1.
- cfg_valid and start are ignored outside IDLE; C is stable while busy.
- fitness and perfect hold their values after done until the next accepted start.
- Widths: the fitness accumulator cannot overflow (max 2^IN*OUT fits in FITW). Vector counter width is IN+1 internally, so there is no wrap at the last vector.

Test Plan:
- Reset -> all outputs 0, cfg_ready=1, busy=0. Defaults used unless stated: 66-bit chromosome.
- Load 66 bits (all LE tables 16'h8000, sel=3), start at cycle 0, with tgt_data generated from a reference grid model -> busy in cycles 1..12, done only at cycle 13, fitness=4, perfect=1.
- Same chromosome with the target inverted -> fitness=0, perfect=0. With OUT=2 and the target wrong on one bit per vector -> fitness=4, perfect=0.
- Send 65 bits then start -> ignored, busy stays 0. Send the 66th bit, then start next cycle -> runs and done follows. Start in the same cycle as the 66th bit -> ignored.
- Start and cfg_valid pulsed during busy -> no effect on C, fitness, or timing. After done, start without reloading -> ignored (bitcnt cleared).
- rst asserted while in APPLY at vec=2 -> next cycle state is IDLE, busy=0, fitness=0, saidas_LE=0, no done pulse.

Source files
------------

// File: rtl/genetic_eval_ctrl.sv
// Serial chromosome loader and truth-table sweep sequencer for the evolvable LE grid.
// Shifts in a chromosome, drives every input vector through the grid and counts output matches.
module genetic_eval_ctrl #(
  parameter int ROW    = 2,
  parameter int COL    = 2,
  parameter int IN     = 2,
  parameter int OUT    = 1,
  parameter int SETTLE = 2,
  localparam int SELW       = $clog2(ROW*COL),
  localparam int CHROM_BITS = ROW*COL*16 + OUT*SELW,
  localparam int FITW       = IN + $clog2(OUT+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic                  cfg_ready,
  input  logic                  start,
  output logic                  busy,
  output logic [ROW*COL*16-1:0] saidas_LE,
  output logic [OUT*SELW-1:0]   out_chrom,
  output logic [IN-1:0]         inp,
  input  logic [OUT-1:0]        out,
  output logic [IN-1:0]         tgt_addr,
  input  logic [OUT-1:0]        tgt_data,
  output logic [FITW-1:0]       fitness,
  output logic                  done,
  output logic                  perfect,
  output logic [1:0]            dbg_state
);

  localparam int BCW = $clog2(CHROM_BITS+1);
  localparam int SCW = $clog2(SETTLE+1);
  localparam int VW  = IN + 1;

  localparam logic [BCW-1:0]  BIT_FULL = BCW'(CHROM_BITS);
  localparam logic [SCW-1:0]  SCNT_END = SCW'(SETTLE-1);
  localparam logic [VW-1:0]   VEC_LAST = VW'((2**IN)-1);
  localparam logic [FITW-1:0] FIT_MAX  = FITW'((2**IN)*OUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state;
  logic [CHROM_BITS-1:0]   chrom;
  logic [BCW-1:0]          bitcnt;
  logic [SCW-1:0]          scnt;
  logic [VW-1:0]           vec;
  logic [FITW-1:0]         match_cnt;
  logic [FITW-1:0]         fit_sum;
  logic                    loaded;

  assign saidas_LE = chrom[CHROM_BITS-1 -: ROW*COL*16];
  assign out_chrom = chrom[OUT*SELW-1:0];
  assign inp       = vec[IN-1:0];
  assign tgt_addr  = vec[IN-1:0];
  assign dbg_state = state;
  assign loaded    = (bitcnt == BIT_FULL);

  // Number of grid output bits agreeing with the target word for the vector on inp.
  always_comb begin
    match_cnt = '0;
    for (int o = 0; o < OUT; o++) begin
      match_cnt = match_cnt + FITW'(out[o] ~^ tgt_data[o]);
    end
    fit_sum = fitness + match_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      chrom     <= '0;
      bitcnt    <= '0;
      scnt      <= '0;
      vec       <= '0;
      fitness   <= '0;
      done      <= 1'b0;
      perfect   <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            chrom <= {chrom[CHROM_BITS-2:0], cfg_bit};
            if (!loaded) bitcnt <= bitcnt + 1'b1;
          end
          // loaded is the registered count, so a start alongside the last bit is ignored
          if (start && loaded) begin
            fitness   <= '0;
            perfect   <= 1'b0;
            vec       <= '0;
            scnt      <= '0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            state     <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (scnt == SCNT_END) begin
            state <= S_SAMPLE;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          fitness <= fit_sum;
          if (vec == VEC_LAST) begin
            perfect <= (fit_sum == FIT_MAX);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else begin
            vec   <= vec + 1'b1;
            scnt  <= '0;
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          bitcnt    <= '0;
          cfg_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
